// File: rtl/spi_flash_wb_reader.sv
// Read-only Wishbone classic window onto an SPI NOR boot flash (READ 0x03, mode 0).
// Chip-select is held after each word so a sequential fetch skips command and address.
module spi_flash_wb_reader #(
    parameter int CLK_DIV        = 2,
    parameter int CS_HOLD_CYCLES = 16,
    parameter int DESEL_CYCLES   = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [23:0] wb_adr_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        spi_ss_o,
    output logic        busy_o
);
    localparam int DW   = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int TMAX = (CS_HOLD_CYCLES > DESEL_CYCLES) ? CS_HOLD_CYCLES : DESEL_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [DW-1:0] DIV_SAMPLE = DW'(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] DESEL_LAST = TW'(DESEL_CYCLES - 1);
    localparam logic [7:0]    CMD_READ   = 8'h03;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SHIFT_CMD  = 3'd1,
        SHIFT_ADDR = 3'd2,
        SHIFT_DATA = 3'd3,
        ACK        = 3'd4,
        HOLD       = 3'd5,
        DESEL      = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [31:0]   tx_q, tx_d;
    logic [31:0]   rx_q, rx_d;
    logic [31:0]   dat_q, dat_d;
    logic [23:0]   addr_q, addr_d;
    logic [23:0]   next_q, next_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          ss_q, ss_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;

    logic        req, rd_req, wr_req;
    logic        shifting, bit_end, sample, start, shift_d;
    logic [23:0] word_adr;
    logic        unused_bits;

    assign req      = wb_cyc_i & wb_stb_i;
    assign rd_req   = req & ~wb_we_i;
    assign wr_req   = req & wb_we_i;
    assign word_adr = {wb_adr_i[23:2], 2'b00};
    assign shifting = (state_q == SHIFT_CMD) || (state_q == SHIFT_ADDR) || (state_q == SHIFT_DATA);
    assign bit_end  = (div_q == DIV_LAST);
    assign sample   = (div_q == DIV_SAMPLE);

    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0]};

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dat_d   = dat_q;
        addr_d  = addr_q;
        next_d  = next_q;
        tmr_d   = tmr_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        start   = 1'b0;

        if (shifting) begin
            div_d = bit_end ? '0 : div_q + DW'(1);
            if (bit_end) begin
                tx_d  = {tx_q[30:0], 1'b0};
                bit_d = bit_q + 5'd1;
            end
        end
        if ((state_q == SHIFT_DATA) && sample) begin
            rx_d = {rx_q[30:0], spi_miso_i};
        end

        unique case (state_q)
            IDLE: begin
                if (wr_req && !err_q) begin
                    err_d = 1'b1;
                end else if (rd_req) begin
                    start = 1'b1;
                end
            end
            SHIFT_CMD: begin
                if (bit_end && (bit_q == 5'd7)) begin
                    state_d = SHIFT_ADDR;
                    bit_d   = '0;
                end
            end
            SHIFT_ADDR: begin
                if (bit_end && (bit_q == 5'd23)) begin
                    state_d = SHIFT_DATA;
                    bit_d   = '0;
                end
            end
            SHIFT_DATA: begin
                // The word finishes even if the master has gone; only the ack depends on req.
                if (bit_end && (bit_q == 5'd31)) begin
                    state_d = ACK;
                    dat_d   = rx_d;
                    ack_d   = req;
                    next_d  = addr_q + 24'd4;
                end
            end
            ACK: begin
                state_d = HOLD;
                tmr_d   = '0;
            end
            HOLD: begin
                if (wr_req && !err_q) begin
                    err_d = 1'b1;
                end
                if (rd_req && (word_adr == next_q)) begin
                    state_d = SHIFT_DATA;
                    addr_d  = next_q;
                    div_d   = '0;
                    bit_d   = '0;
                end else if (rd_req) begin
                    state_d = DESEL;
                    pend_d  = 1'b1;
                    tmr_d   = '0;
                end else if (tmr_q == HOLD_LAST) begin
                    state_d = DESEL;
                    pend_d  = 1'b0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            DESEL: begin
                if (tmr_q == DESEL_LAST) begin
                    pend_d  = 1'b0;
                    state_d = IDLE;
                    start   = pend_q & rd_req;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = SHIFT_CMD;
            addr_d  = word_adr;
            tx_d    = {CMD_READ, word_adr};
            div_d   = '0;
            bit_d   = '0;
        end

        // Pad outputs are registered from next-state values so they never glitch.
        shift_d = (state_d == SHIFT_CMD) || (state_d == SHIFT_ADDR) || (state_d == SHIFT_DATA);
        ss_d    = (state_d == IDLE) || (state_d == DESEL);
        sck_d   = shift_d && (div_d >= DIV_SAMPLE);
        mosi_d  = ((state_d == SHIFT_CMD) || (state_d == SHIFT_ADDR)) && tx_d[31];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dat_q   <= '0;
            addr_q  <= '0;
            next_q  <= '0;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ss_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ss_q    <= ss_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign spi_ss_o   = ss_q;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;
    assign busy_o     = (state_q != IDLE);

endmodule
